// File: rtl/buffer_arbiter_pkg.sv
// Shared encodings for the buffer arbiter: buffer mode values, mode-FSM states
// and the last-operation marker used to alternate reads and writes.
package buffer_arbiter_pkg;

    localparam logic MODE_FIFO = 1'b1;
    localparam logic MODE_LIFO = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } mode_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/buffer_arbiter_if.sv
// Pin bundle between the arbiter (master) and the circular buffer (slave).
interface buffer_arbiter_if #(
    parameter int WIDTH = 32
);
    // Strobe semantics: buf_wr and buf_rd are single-cycle commands that the
    // buffer accepts unconditionally on the rising edge they are high; the
    // master only raises buf_wr when !buf_full and buf_rd when !buf_empty, and
    // never both together. buf_out holds the word popped by the last buf_rd.
    logic             buf_wr;
    logic             buf_rd;
    logic             buf_fifo;
    logic [WIDTH-1:0] buf_in;
    logic             buf_full;
    logic             buf_empty;
    logic [WIDTH-1:0] buf_out;

    modport master (
        output buf_wr, buf_rd, buf_fifo, buf_in,
        input  buf_full, buf_empty, buf_out
    );

    modport slave (
        input  buf_wr, buf_rd, buf_fifo, buf_in,
        output buf_full, buf_empty, buf_out
    );

endinterface

// File: rtl/buffer_arbiter_rr_arbiter.sv
// Round-robin grant over REQ requesters; the pointer moves past the winner only
// when the grant is actually used (en high).
module rr_arbiter #(
    parameter int REQ = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [REQ-1:0] req,
    input  logic           en,
    output logic [REQ-1:0] gnt
);

    localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < REQ; i++) begin
            idx = PW'((int'(ptr) + i) % REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        if (en && found) gnt[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (sel == PW'(REQ - 1)) ? '0 : sel + PW'(1);
        end
    end

endmodule

// File: rtl/buffer_arbiter.sv
// Shares one circular buffer among REQ writers and one reader, alternating
// reads and writes and changing FIFO/LIFO mode only once the buffer is empty.
module buffer_arbiter
    import buffer_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int REQ   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ-1:0]             wr_req,
    input  logic [REQ*WIDTH-1:0]       wr_data,
    output logic [REQ-1:0]             wr_gnt,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    input  logic                       mode_sel,
    output logic                       mode_busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full,
    output mode_state_t                mode_state,
    buffer_arbiter_if.master           bus
);

    localparam int LW = $clog2(DEPTH + 1);

    mode_state_t      state;
    mode_state_t      state_nx;
    op_t              last_op;
    logic             fifo_q;
    logic             rd_pend;
    logic             write_ok;
    logic             read_ok;
    logic             do_write;
    logic             do_read;
    logic [WIDTH-1:0] buf_in_w;

    assign write_ok = (|wr_req) && (level < LW'(DEPTH)) && !bus.buf_full && (state == ST_RUN);
    assign read_ok  = rd_req && (level != '0) && !bus.buf_empty && (state != ST_SWITCH);

    // When both sides are eligible the opposite of the last issued op wins.
    assign do_write = write_ok && (!read_ok || (last_op == OP_READ));
    assign do_read  = read_ok && (!write_ok || (last_op == OP_WRITE));

    rr_arbiter #(.REQ(REQ)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .en  (do_write),
        .gnt (wr_gnt)
    );

    always_comb begin
        buf_in_w = '0;
        for (int i = 0; i < REQ; i++) begin
            if (wr_gnt[i]) buf_in_w = wr_data[i*WIDTH +: WIDTH];
        end
    end

    assign bus.buf_wr   = do_write;
    assign bus.buf_rd   = do_read;
    assign bus.buf_in   = buf_in_w;
    assign bus.buf_fifo = fifo_q;

    assign almost_full = (level >= LW'(DEPTH - 1));
    assign mode_state  = state;

    always_comb begin
        state_nx  = state;
        mode_busy = 1'b0;
        case (state)
            ST_RUN: begin
                if (mode_sel != fifo_q) begin
                    state_nx  = ST_DRAIN;
                    mode_busy = 1'b1;
                end
            end
            ST_DRAIN: begin
                mode_busy = 1'b1;
                if (mode_sel == fifo_q) state_nx = ST_RUN;
                else if (level == '0)   state_nx = ST_SWITCH;
            end
            ST_SWITCH: begin
                mode_busy = 1'b1;
                state_nx  = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            fifo_q   <= MODE_FIFO;
            last_op  <= OP_READ;
            level    <= '0;
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_SWITCH) fifo_q <= mode_sel;
            if (do_write) begin
                last_op <= OP_WRITE;
                level   <= level + LW'(1);
            end else if (do_read) begin
                last_op <= OP_READ;
                level   <= level - LW'(1);
            end
            // The buffer registers its output on buf_rd, so capture one cycle later.
            rd_pend  <= do_read;
            rd_valid <= rd_pend;
            if (rd_pend) rd_data <= bus.buf_out;
        end
    end

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter with a behavioural depth-4 FIFO/LIFO buffer.
module tb_buffer_arbiter;
    import buffer_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   wr_req;
    logic [127:0] wr_data;
    logic [3:0]   wr_gnt;
    logic         rd_req;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic         mode_sel;
    logic         mode_busy;
    logic [2:0]   level;
    logic         almost_full;
    mode_state_t  mode_state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    int gcount[4];

    buffer_arbiter_if #(.WIDTH(32)) bus();

    buffer_arbiter #(.WIDTH(32), .DEPTH(4), .REQ(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mode_sel    (mode_sel),
        .mode_busy   (mode_busy),
        .level       (level),
        .almost_full (almost_full),
        .mode_state  (mode_state),
        .bus         (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // behavioural circular buffer: registered output on rd
    logic [31:0] mq[$];
    logic [31:0] m_out;
    int          m_cnt;
    assign bus.buf_out   = m_out;
    assign bus.buf_full  = (m_cnt == 4);
    assign bus.buf_empty = (m_cnt == 0);

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_out <= '0;
        end else begin
            if (bus.buf_rd && mq.size() > 0) begin
                if (bus.buf_fifo) m_out <= mq.pop_front();
                else              m_out <= mq.pop_back();
            end
            if (bus.buf_wr && mq.size() < 4) mq.push_back(bus.buf_in);
        end
        m_cnt <= mq.size();
    end

    // driver / checker tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        wr_data[i*32 +: 32] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_req = '0;
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic sample_read();
        chk("both_ops", 32'(bus.buf_wr & bus.buf_rd), 32'd0);
        if (rd_valid) begin
            if (exp_q.size() > 0) chk("rd_data", rd_data, exp_q.pop_front());
            else                  chk("rd_extra", 32'(rd_valid), 32'd0);
        end
    endtask

    // drains the buffer until every expected word has been seen; ends mid-cycle
    task automatic read_all(input int budget);
        for (int c = 0; c < budget; c++) begin
            rd_req = (level != 3'd0);
            #1;
            sample_read();
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("rd_timeout", 32'(exp_q.size()), 32'd0);
        rd_req = 1'b0;
    endtask

    task automatic write_one(input int r, input logic [31:0] v, input string tag);
        wr_req = 4'(1 << r);
        set_word(r, v);
        #1;
        chk(tag, 32'(wr_gnt), 32'(1 << r));
        step();
        wr_req = '0;
    endtask

    initial begin
        logic [31:0] vals [4];
        vals[0] = 32'h69; vals[1] = 32'h420; vals[2] = 32'h260; vals[3] = 32'h124;
        wr_data  = '0;
        mode_sel = MODE_FIFO;
        do_reset();

        // reset state
        #1;
        chk("rst_wr_gnt", 32'(wr_gnt), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_buf_fifo", 32'(bus.buf_fifo), 32'd1);
        chk("rst_buf_wr", 32'(bus.buf_wr), 32'd0);
        chk("rst_buf_rd", 32'(bus.buf_rd), 32'd0);
        chk("rst_buf_in", bus.buf_in, 32'd0);
        chk("rst_mode_busy", 32'(mode_busy), 32'd0);
        step();

        // requester 0 fills the buffer, then reader empties it in FIFO order
        for (int k = 0; k < 4; k++) begin
            wr_req = 4'b0001;
            set_word(0, vals[k]);
            #1;
            chk("t1_gnt", 32'(wr_gnt), 32'd1);
            chk("t1_buf_wr", 32'(bus.buf_wr), 32'd1);
            chk("t1_buf_in", bus.buf_in, vals[k]);
            chk("t1_level", 32'(level), 32'(k));
            chk("t1_almost_full", 32'(almost_full), (k >= 3) ? 32'd1 : 32'd0);
            exp_q.push_back(vals[k]);
            step();
        end
        #1;
        chk("t1_full_level", 32'(level), 32'd4);
        chk("t1_full_af", 32'(almost_full), 32'd1);
        chk("t1_full_no_gnt", 32'(wr_gnt), 32'd0);
        chk("t1_full_no_wr", 32'(bus.buf_wr), 32'd0);
        wr_req = '0;
        step();
        read_all(20);
        chk("t1_level_end", 32'(level), 32'd0);
        step();

        // four requesters contending: one grant each in rotation, then stall at full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_word(i, 32'hA0 + 32'(i));
            gcount[i] = 0;
        end
        wr_req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t2_gnt", 32'(wr_gnt), (k < 4) ? 32'(1 << k) : 32'd0);
            if (k < 4) chk("t2_buf_in", bus.buf_in, 32'hA0 + 32'(k));
            for (int i = 0; i < 4; i++) if (wr_gnt[i]) gcount[i]++;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t2_once", 32'(gcount[i]), 32'd1);
            exp_q.push_back(32'hA0 + 32'(i));
        end
        wr_req = '0;
        read_all(20);
        step();

        // level 2 with both sides requesting: strict alternation, read first
        write_one(1, 32'h11, "t3_pre_gnt");
        write_one(1, 32'h22, "t3_pre_gnt");
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        wr_req = 4'b0001;
        rd_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_word(0, 32'h30 + 32'(c));
            #1;
            chk("t3_buf_rd", 32'(bus.buf_rd), (c % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_buf_wr", 32'(bus.buf_wr), (c % 2 == 0) ? 32'd0 : 32'd1);
            chk("t3_level", 32'(level), (c % 2 == 0) ? 32'd2 : 32'd1);
            sample_read();
            if (c % 2 == 1) exp_q.push_back(32'h30 + 32'(c));
            step();
        end
        wr_req = '0;
        read_all(20);
        step();

        // mode request withdrawn while draining: stays FIFO, writes resume
        write_one(0, 32'h55, "t5_gnt");
        mode_sel = MODE_LIFO;
        #1;
        chk("t5_busy", 32'(mode_busy), 32'd1);
        step();
        chk("t5_drain", 32'(mode_state), 32'(ST_DRAIN));
        mode_sel = MODE_FIFO;
        step();
        wr_req = 4'b0001;
        set_word(0, 32'h56);
        #1;
        chk("t5_resume_gnt", 32'(wr_gnt), 32'd1);
        chk("t5_buf_fifo", 32'(bus.buf_fifo), 32'd1);
        chk("t5_state", 32'(mode_state), 32'(ST_RUN));
        chk("t5_busy_clear", 32'(mode_busy), 32'd0);
        step();
        wr_req = '0;
        exp_q.push_back(32'h55);
        exp_q.push_back(32'h56);
        read_all(20);
        step();

        // switch FIFO -> LIFO with 3 words stored
        write_one(2, 32'h71, "t4_gnt");
        write_one(2, 32'h72, "t4_gnt");
        write_one(2, 32'h73, "t4_gnt");
        exp_q.push_back(32'h71);
        exp_q.push_back(32'h72);
        exp_q.push_back(32'h73);
        mode_sel = MODE_LIFO;
        #1;
        chk("t4_busy", 32'(mode_busy), 32'd1);
        step();
        wr_req = 4'b0100;
        set_word(2, 32'h99);
        rd_req = 1'b1;
        #1;
        chk("t4_wr_blocked", 32'(wr_gnt), 32'd0);
        chk("t4_drain_rd", 32'(bus.buf_rd), 32'd1);
        chk("t4_drain", 32'(mode_state), 32'(ST_DRAIN));
        wr_req = '0;
        step();
        read_all(20);
        chk("t4_switch", 32'(mode_state), 32'(ST_SWITCH));
        chk("t4_fifo_held", 32'(bus.buf_fifo), 32'd1);
        chk("t4_switch_busy", 32'(mode_busy), 32'd1);
        step();
        chk("t4_lifo", 32'(bus.buf_fifo), 32'd0);
        chk("t4_run", 32'(mode_state), 32'(ST_RUN));
        chk("t4_busy_clear", 32'(mode_busy), 32'd0);
        write_one(3, 32'd1, "t4_lifo_gnt");
        write_one(3, 32'd2, "t4_lifo_gnt");
        write_one(3, 32'd3, "t4_lifo_gnt");
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd1);
        read_all(20);
        step();

        // reset lands while a read is in flight
        write_one(0, 32'h77, "t6_gnt");
        rd_req = 1'b1;
        #1;
        chk("t6_buf_rd", 32'(bus.buf_rd), 32'd1);
        step();
        rd_req   = 1'b0;
        rst      = 1'b1;
        mode_sel = MODE_FIFO;
        step();
        rst = 1'b0;
        #1;
        chk("t6_rd_valid", 32'(rd_valid), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_buf_fifo", 32'(bus.buf_fifo), 32'd1);
        chk("t6_wr_gnt", 32'(wr_gnt), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_no_valid", 32'(rd_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buffer_arbiter.md
Name: buffer_arbiter

Overview:
Controller that shares one circular_buffer instance (32-bit, depth 4, FIFO/LIFO selectable) among REQ write requesters and one reader. It round-robins writers, interleaves reads with writes, tracks occupancy itself, and changes the buffer's FIFO/LIFO mode only when the buffer is empty. It sits directly in front of the buffer and is the only driver of the buffer's wr, rd, fifo and in pins.

Parameters:
WIDTH, 32, data word width (matches buffer width)
DEPTH, 4, buffer depth in words (matches buffer depth)
REQ, 4, number of write requesters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_req  in  REQ  per-requester write request (level, held until granted)
wr_data  in  REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
wr_gnt  out  REQ  one-hot grant; word of granted requester is written this cycle
rd_req  in  1  reader request (level)
rd_valid  out  1  rd_data valid strobe
rd_data  out  WIDTH  word read from buffer
mode_sel  in  1  requested mode: 1 = FIFO, 0 = LIFO
mode_busy  out  1  mode change pending (mode_sel differs from applied mode)
level  out  clog2(DEPTH+1)  words currently stored, 0..DEPTH
almost_full  out  1  level >= DEPTH-1
buf_wr  out  1  to buffer wr
buf_rd  out  1  to buffer rd
buf_fifo  out  1  to buffer fifo
buf_in  out  WIDTH  to buffer in
buf_full  in  1  from buffer full
buf_empty  in  1  from buffer empty
buf_out  in  WIDTH  from buffer out

Behaviour:
- Reset: wr_gnt=0, rd_valid=0, rd_data=0, buf_wr=0, buf_rd=0, buf_in=0, level=0, buf_fifo=1 (FIFO), round-robin pointer=0, last_op=READ. Reset mid-operation discards any in-flight read; no rd_valid follows.
- At most one buffer operation per cycle; buf_wr and buf_rd are never both 1.
- Eligibility: write_ok = |wr_req && level<DEPTH && !buf_full && !mode_switch; read_ok = rd_req && level>0 && !buf_empty && !mode_switch.
- Op select: only one eligible -> do it; both eligible -> do opposite of last_op (strict alternation); last_op updated only when an op issues.
- Write: grant first requesting index at or after pointer (wrapping REQ-1 -> 0). Same cycle, combinationally: wr_gnt one-hot, buf_wr=1, buf_in=wr_data of granted index. Pointer <= granted index + 1 mod REQ. Requester may drop wr_req the cycle after grant.
- Read: buf_rd=1 combinationally; next cycle rd_valid=1 and rd_data<=buf_out is registered (1-cycle latency). rd_valid is a one-cycle pulse per read; back-to-back reads produce consecutive pulses.
- level: +1 on write, -1 on read, registered; never wraps (write blocked at DEPTH, read blocked at 0). Internal level is authoritative; buf_full/buf_empty act only as additional guards.
- Mode FSM states: RUN, DRAIN, SWITCH. RUN: mode_sel!=buf_fifo -> DRAIN, mode_busy=1. DRAIN: writes blocked, reads continue in current mode; level==0 -> SWITCH. SWITCH (1 cycle, no ops): buf_fifo<=mode_sel -> RUN. If mode_sel reverts to buf_fifo during DRAIN -> RUN immediately, writes re-enabled. mode_busy=1 in DRAIN and SWITCH. mode_switch=(state==SWITCH); writes also blocked in DRAIN.
- buf_fifo changes only in SWITCH, so the buffer's mode never changes while it holds data.

Decomposition:
- Shared package/header: MODE_FIFO=1, MODE_LIFO=0, mode-FSM state encodings (RUN, DRAIN, SWITCH), OP_READ/OP_WRITE encodings for last_op.
- One sub-module: rr_arbiter (REQ-wide round-robin grant with rotating pointer and enable input), reusable elsewhere.

Test Plan:
- Reset, FIFO mode, requester 0 writes 'h69,'h420,'h260,'h124 -> wr_gnt=0001 four cycles, level 1..4, almost_full at 3; then rd_req -> rd_valid pulses with 'h69,'h420,'h260,'h124, level 4..0.
- All four requesters request continuously, data 'hA0+i -> grants 0001,0010,0100,1000,then stall when level=4; each requester granted exactly once.
- Level 2, wr_req and rd_req both held -> buf_wr/buf_rd alternate every cycle, level stays within 1..3, never both high.
- FIFO, 3 words stored, mode_sel=0 -> mode_busy=1, writes blocked, 3 reads in FIFO order, one SWITCH cycle, buf_fifo=0; write 1,2,3 then read -> 3,2,1.
- mode_sel toggled to 0 then back to 1 during DRAIN -> returns to RUN, buf_fifo stays 1, writes resume next cycle.
- rst asserted the cycle after buf_rd -> no rd_valid, level=0, buf_fifo=1, wr_gnt=0.
